cache_rate_monitor: RTL and testbench

//  Parametrised hit/miss performance monitor for NCH cache ports (e.g. I$/D$).
//  Per channel: saturating total hit/miss counters, fixed-size access windows

---
 rtl/cache_rate_monitor.sv | 188 ++++++++++++++++++
 tb/tb_cache_rate_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rate_monitor.sv
// cache_rate_monitor: per-channel cache hit/miss monitor with fixed-size
// access windows, per-window miss count, window-done pulse and sticky alarm.
// Ports: clk, rst (async, active-high), clr (sync clear), freeze (hold),
//   acc_vld/acc_miss/acc_wr [NCH] access strobes, sel channel readout select,
//   rd_hit/rd_miss/rd_win_miss/rd_wr_miss registered readout of channel sel,
//   win_done [NCH] window-closed pulse, alarm [NCH] sticky threshold alarm.
// Optional: define CRM_WR_SPLIT_EN to add per-channel write-miss counters.
module cache_rate_monitor #(
    parameter int NCH    = 2,
    parameter int CNT_W  = 32,
    parameter int WINDOW = 64,
    parameter int THRESH = 8,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int WM_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             freeze,
    input  logic [NCH-1:0]   acc_vld,
    input  logic [NCH-1:0]   acc_miss,
    input  logic [NCH-1:0]   acc_wr,
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] rd_hit,
    output logic [CNT_W-1:0] rd_miss,
    output logic [WM_W-1:0]  rd_win_miss,
    output logic [CNT_W-1:0] rd_wr_miss,
    output logic [NCH-1:0]   win_done,
    output logic [NCH-1:0]   alarm
);

    typedef enum logic {W_IDLE, W_RUN} w_state_e;

    localparam logic [WM_W-1:0] WIN_L = WM_W'(WINDOW);

    logic [CNT_W-1:0] hit_q      [NCH];
    logic [CNT_W-1:0] hit_d      [NCH];
    logic [CNT_W-1:0] miss_q     [NCH];
    logic [CNT_W-1:0] miss_d     [NCH];
    logic [WM_W-1:0]  acc_cnt_q  [NCH];
    logic [WM_W-1:0]  acc_cnt_d  [NCH];
    logic [WM_W-1:0]  cur_miss_q [NCH];
    logic [WM_W-1:0]  cur_miss_d [NCH];
    logic [WM_W-1:0]  win_miss_q [NCH];
    logic [WM_W-1:0]  win_miss_d [NCH];
    w_state_e         state_q    [NCH];
    w_state_e         state_d    [NCH];
    logic [NCH-1:0]   done_q, done_d;
    logic [NCH-1:0]   alarm_q, alarm_d;
    logic [CNT_W-1:0] rd_hit_q, rd_hit_d;
    logic [CNT_W-1:0] rd_miss_q, rd_miss_d;
    logic [WM_W-1:0]  rd_win_q, rd_win_d;
    logic [CNT_W-1:0] rd_wr_q, rd_wr_d;
    logic             sel_ok;

`ifdef CRM_WR_SPLIT_EN
    logic [CNT_W-1:0] wrm_q [NCH];
    logic [CNT_W-1:0] wrm_d [NCH];
`else
    logic unused_wr;
    assign unused_wr = ^acc_wr;
`endif

    assign sel_ok = 32'(sel) < NCH;

    always_comb begin
        logic [WM_W-1:0] cnt_nxt;
        logic [WM_W-1:0] mis_nxt;
        cnt_nxt = '0;
        mis_nxt = '0;
        done_d  = '0;
        alarm_d = alarm_q;
        for (int i = 0; i < NCH; i++) begin
            hit_d[i]      = hit_q[i];
            miss_d[i]     = miss_q[i];
            acc_cnt_d[i]  = acc_cnt_q[i];
            cur_miss_d[i] = cur_miss_q[i];
            win_miss_d[i] = win_miss_q[i];
            state_d[i]    = state_q[i];
`ifdef CRM_WR_SPLIT_EN
            wrm_d[i]      = wrm_q[i];
`endif
            if (clr) begin
                hit_d[i]      = '0;
                miss_d[i]     = '0;
                acc_cnt_d[i]  = '0;
                cur_miss_d[i] = '0;
                win_miss_d[i] = '0;
                state_d[i]    = W_IDLE;
                alarm_d[i]    = 1'b0;
`ifdef CRM_WR_SPLIT_EN
                wrm_d[i]      = '0;
`endif
            end else if (!freeze && acc_vld[i]) begin
                if (!acc_miss[i] && hit_q[i] != '1)
                    hit_d[i] = hit_q[i] + 1'b1;
                if (acc_miss[i] && miss_q[i] != '1)
                    miss_d[i] = miss_q[i] + 1'b1;
`ifdef CRM_WR_SPLIT_EN
                if (acc_miss[i] && acc_wr[i] && wrm_q[i] != '1)
                    wrm_d[i] = wrm_q[i] + 1'b1;
`endif
                // An idle window starts counting from this access.
                cnt_nxt = (state_q[i] == W_IDLE) ? WM_W'(1)
                                                 : acc_cnt_q[i] + 1'b1;
                mis_nxt = ((state_q[i] == W_IDLE) ? '0 : cur_miss_q[i])
                        + WM_W'(acc_miss[i]);
                if (cnt_nxt == WIN_L) begin
                    win_miss_d[i] = mis_nxt;
                    acc_cnt_d[i]  = '0;
                    cur_miss_d[i] = '0;
                    done_d[i]     = 1'b1;
                    state_d[i]    = W_IDLE;
                    if (32'(mis_nxt) > THRESH)
                        alarm_d[i] = 1'b1;
                end else begin
                    acc_cnt_d[i]  = cnt_nxt;
                    cur_miss_d[i] = mis_nxt;
                    state_d[i]    = W_RUN;
                end
            end
        end
    end

    // Readout samples pre-update state; out-of-range channels read as zero.
    always_comb begin
        rd_hit_d  = '0;
        rd_miss_d = '0;
        rd_win_d  = '0;
        rd_wr_d   = '0;
        if (!clr && sel_ok) begin
            rd_hit_d  = hit_q[sel];
            rd_miss_d = miss_q[sel];
            rd_win_d  = win_miss_q[sel];
`ifdef CRM_WR_SPLIT_EN
            rd_wr_d   = wrm_q[sel];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                hit_q[i]      <= '0;
                miss_q[i]     <= '0;
                acc_cnt_q[i]  <= '0;
                cur_miss_q[i] <= '0;
                win_miss_q[i] <= '0;
                state_q[i]    <= W_IDLE;
`ifdef CRM_WR_SPLIT_EN
                wrm_q[i]      <= '0;
`endif
            end
            done_q    <= '0;
            alarm_q   <= '0;
            rd_hit_q  <= '0;
            rd_miss_q <= '0;
            rd_win_q  <= '0;
            rd_wr_q   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                hit_q[i]      <= hit_d[i];
                miss_q[i]     <= miss_d[i];
                acc_cnt_q[i]  <= acc_cnt_d[i];
                cur_miss_q[i] <= cur_miss_d[i];
                win_miss_q[i] <= win_miss_d[i];
                state_q[i]    <= state_d[i];
`ifdef CRM_WR_SPLIT_EN
                wrm_q[i]      <= wrm_d[i];
`endif
            end
            done_q    <= done_d;
            alarm_q   <= alarm_d;
            rd_hit_q  <= rd_hit_d;
            rd_miss_q <= rd_miss_d;
            rd_win_q  <= rd_win_d;
            rd_wr_q   <= rd_wr_d;
        end
    end

    assign rd_hit      = rd_hit_q;
    assign rd_miss     = rd_miss_q;
    assign rd_win_miss = rd_win_q;
    assign rd_wr_miss  = rd_wr_q;
    assign win_done    = done_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_cache_rate_monitor.sv
// tb_cache_rate_monitor: directed bench for cache_rate_monitor with an
// arithmetic reference model and a per-cycle compare process.
module tb_cache_rate_monitor;

    localparam int NCH = 3;
    localparam int CW  = 6;
    localparam int WIN = 8;
    localparam int TH  = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef CRM_WR_SPLIT_EN
    localparam int EXP_WR = 3;
`else
    localparam int EXP_WR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic freeze = 1'b0;
    logic [2:0] acc_vld = '0;
    logic [2:0] acc_miss = '0;
    logic [2:0] acc_wr = '0;
    logic [1:0] sel = '0;
    logic [CW-1:0] rd_hit, rd_miss, rd_wr_miss;
    logic [3:0] rd_win_miss;
    logic [2:0] win_done, alarm;

    logic w1_sel = 1'b0;
    logic [CW-1:0] w1_hit, w1_miss, w1_wr;
    logic [0:0] w1_win;
    logic [0:0] w1_done, w1_alarm;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_rate_monitor #(.NCH(NCH), .CNT_W(CW), .WINDOW(WIN), .THRESH(TH)) dut (
        .clk(clk), .rst(rst), .clr(clr), .freeze(freeze),
        .acc_vld(acc_vld), .acc_miss(acc_miss), .acc_wr(acc_wr), .sel(sel),
        .rd_hit(rd_hit), .rd_miss(rd_miss), .rd_win_miss(rd_win_miss),
        .rd_wr_miss(rd_wr_miss), .win_done(win_done), .alarm(alarm)
    );

    cache_rate_monitor #(.NCH(1), .CNT_W(CW), .WINDOW(1), .THRESH(0)) dut_w1 (
        .clk(clk), .rst(rst), .clr(clr), .freeze(freeze),
        .acc_vld(acc_vld[0]), .acc_miss(acc_miss[0]), .acc_wr(acc_wr[0]),
        .sel(w1_sel),
        .rd_hit(w1_hit), .rd_miss(w1_miss), .rd_win_miss(w1_win),
        .rd_wr_miss(w1_wr), .win_done(w1_done), .alarm(w1_alarm)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: totals, position in window, and last closed window.
    int m_hit [NCH], m_miss [NCH], m_wr [NCH], m_pos [NCH], m_cur [NCH];
    int m_last [NCH];
    bit [2:0] m_done, m_alarm;
    int e_hit, e_miss, e_win, e_wr;
    int w1_last, w1_ehit, w1_emiss, w1_ewin, w1_ewr;
    bit w1_mdone, w1_malarm;

    task automatic model_zero();
        for (int i = 0; i < NCH; i++) begin
            m_hit[i] = 0; m_miss[i] = 0; m_wr[i] = 0;
            m_pos[i] = 0; m_cur[i] = 0; m_last[i] = 0;
        end
        m_done = '0; m_alarm = '0;
        e_hit = 0; e_miss = 0; e_win = 0; e_wr = 0;
        w1_last = 0; w1_ehit = 0; w1_emiss = 0; w1_ewin = 0; w1_ewr = 0;
        w1_mdone = 0; w1_malarm = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            model_zero();
        end else begin
            if (int'(sel) < NCH) begin
                e_hit = m_hit[sel]; e_miss = m_miss[sel];
                e_win = m_last[sel]; e_wr = m_wr[sel];
            end else begin
                e_hit = 0; e_miss = 0; e_win = 0; e_wr = 0;
            end
            w1_ehit = m_hit[0]; w1_emiss = m_miss[0];
            w1_ewin = w1_last; w1_ewr = m_wr[0];
            m_done = '0;
            w1_mdone = 0;
            for (int i = 0; i < NCH; i++) begin
                if (!freeze && acc_vld[i]) begin
                    if (acc_miss[i]) begin
                        if (m_miss[i] < CMAX) m_miss[i]++;
`ifdef CRM_WR_SPLIT_EN
                        if (acc_wr[i] && m_wr[i] < CMAX) m_wr[i]++;
`endif
                    end else if (m_hit[i] < CMAX) begin
                        m_hit[i]++;
                    end
                    m_pos[i]++;
                    m_cur[i] += int'(acc_miss[i]);
                    if (m_pos[i] == WIN) begin
                        m_last[i] = m_cur[i];
                        if (m_cur[i] > TH) m_alarm[i] = 1;
                        m_done[i] = 1;
                        m_pos[i] = 0;
                        m_cur[i] = 0;
                    end
                    if (i == 0) begin
                        w1_mdone = 1;
                        w1_last = int'(acc_miss[0]);
                        if (acc_miss[0]) w1_malarm = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_hit", rd_hit, e_hit);
            chk("rd_miss", rd_miss, e_miss);
            chk("rd_win_miss", rd_win_miss, e_win);
            chk("rd_wr_miss", rd_wr_miss, e_wr);
            chk("win_done", win_done, m_done);
            chk("alarm", alarm, m_alarm);
            chk("w1_rd_hit", w1_hit, w1_ehit);
            chk("w1_rd_miss", w1_miss, w1_emiss);
            chk("w1_rd_win", w1_win, w1_ewin);
            chk("w1_rd_wr", w1_wr, w1_ewr);
            chk("w1_done", w1_done, w1_mdone);
            chk("w1_alarm", w1_alarm, w1_malarm);
        end
    end

    task automatic step(input logic [2:0] v, input logic [2:0] m,
                        input logic [2:0] w);
        acc_vld = v; acc_miss = m; acc_wr = w;
        @(negedge clk);
        acc_vld = '0; acc_miss = '0; acc_wr = '0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step('0, '0, '0);
        chk("lit_reset_hit", rd_hit, 0);
        chk("lit_reset_alarm", alarm, 0);
        chk("lit_reset_done", win_done, 0);

        // One miss then 25 hits on channel 0.
        sel = 2'd0;
        step(3'b001, 3'b001, '0);
        chk("lit_w1_done", w1_done, 1);
        chk("lit_w1_alarm", w1_alarm, 1);
        repeat (25) step(3'b001, '0, '0);
        step('0, '0, '0);
        chk("lit_t1_hit", rd_hit, 25);
        chk("lit_t1_miss", rd_miss, 1);
        do_clr();

        // Window of 8 on channel 1 with 3 misses, then a clean window.
        sel = 2'd1;
        for (int k = 0; k < 8; k++)
            step(3'b010, (k == 0 || k == 2 || k == 4) ? 3'b010 : 3'b000, '0);
        chk("lit_t2_done", win_done[1], 1);
        chk("lit_t2_alarm", alarm[1], 1);
        step('0, '0, '0);
        chk("lit_t2_done_pulse", win_done[1], 0);
        chk("lit_t2_win", rd_win_miss, 3);
        repeat (8) step(3'b010, '0, '0);
        step('0, '0, '0);
        chk("lit_t2_sticky", alarm[1], 1);
        chk("lit_t2_win0", rd_win_miss, 0);

        // Saturation of the hit counter on channel 2.
        sel = 2'd2;
        repeat (70) step(3'b100, '0, '0);
        step('0, '0, '0);
        chk("lit_t3_sat", rd_hit, CMAX);
        do_clr();
        step('0, '0, '0);
        chk("lit_t3_clr", rd_hit, 0);

        // clr wins over a simultaneous miss; window restarts from zero.
        sel = 2'd0;
        clr = 1'b1;
        step(3'b001, 3'b001, '0);
        clr = 1'b0;
        step('0, '0, '0);
        chk("lit_t4_miss", rd_miss, 0);
        repeat (7) step(3'b001, '0, '0);
        chk("lit_t4_open", win_done[0], 0);
        step(3'b001, '0, '0);
        chk("lit_t4_close", win_done[0], 1);

        // Concurrent channels; a freeze cycle drops its accesses.
        do_clr();
        repeat (4) step(3'b011, 3'b010, '0);
        freeze = 1'b1;
        step(3'b011, 3'b010, '0);
        freeze = 1'b0;
        step(3'b001, '0, '0);
        step('0, '0, '0);
        chk("lit_t5_hit0", rd_hit, 5);
        chk("lit_t5_miss0", rd_miss, 0);
        sel = 2'd1;
        step('0, '0, '0);
        chk("lit_t5_hit1", rd_hit, 0);
        chk("lit_t5_miss1", rd_miss, 4);
        sel = 2'd3;
        step('0, '0, '0);
        chk("lit_t5_oor", rd_miss, 0);

        // Write-miss split, then asynchronous reset mid-window.
        do_clr();
        sel = 2'd0;
        repeat (3) step(3'b001, 3'b001, 3'b001);
        repeat (2) step(3'b001, 3'b001, '0);
        step(3'b001, '0, 3'b001);
        step('0, '0, '0);
        chk("lit_t6_wr", rd_wr_miss, EXP_WR);
        chk("lit_t6_miss", rd_miss, 5);
        repeat (3) step(3'b010, 3'b010, '0);
        #2 rst = 1'b1;
        #1;
        chk("lit_rst_hit", rd_hit, 0);
        chk("lit_rst_miss", rd_miss, 0);
        chk("lit_rst_wr", rd_wr_miss, 0);
        chk("lit_rst_alarm", alarm, 0);
        chk("lit_rst_w1", w1_alarm, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step('0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
